imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the core's instruction fetch port. It fills instruction memory from a byte stream; the core only ever reads that memory.
- Accepts a framed byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words to word-addressed instruction memory starting at address 0.
- Holds the processor in reset (core_rst) until a load completes with a good checksum.

Parameters:
ISIZE, 32, instruction word width (fixed at 4 bytes).
AW, 8, instruction memory word-address width.
DEPTH, 256, maximum words per load; must be <= 2^AW.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  begin load session; sampled in IDLE, DONE and ERR only
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader can accept a byte; a transfer occurs when byte_valid & byte_ready
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_waddr  output  AW  word address of the write
imem_wdata  output  ISIZE  instruction word
core_rst  output  1  reset to the processor; high except in DONE
busy  output  1  high in HDR0, HDR1, DATA, CSUM
done  output  1  load succeeded; level, held until next start or rst
error  output  1  load failed; level, held until next start or rst

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, core_rst=1, byte_ready=0, busy=0, done=0, error=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - Applies mid-load: any pending word write is dropped. Words already written stay in memory.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4N payload bytes, then CSUM. CSUM is the XOR of all payload bytes.
- States: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR. All outputs are registered.
- IDLE:
  - byte_ready=0; stream bytes are not consumed.
  - start -> HDR0; core_rst=1, done=0, error=0.
- HDR0: byte_ready=1; on transfer, capture len[7:0] -> HDR1.
- HDR1:
  - On transfer, capture len[15:8].
  - If len==0 or len>DEPTH -> ERR.
  - Otherwise -> DATA with word index=0, byte index=0, checksum accumulator=0.
- DATA:
  - byte_ready=1. Each transfer XORs the byte into the accumulator.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k].
  - The transfer completing byte 3 at edge t produces, in the cycle after t: imem_we=1, imem_waddr=word index, imem_wdata=assembled word. The word index then increments.
  - byte_ready stays 1 during the write cycle, so back-to-back bytes are allowed.
  - After byte 3 of word N-1 -> CSUM.
- CSUM:
  - byte_ready=1; on transfer compare the byte with the accumulator.
  - Equal -> DONE; not equal -> ERR.
- DONE:
  - done=1, core_rst=0, byte_ready=0.
  - start -> HDR0 with core_rst=1 and done=0 on the same edge.
- ERR:
  - error=1, core_rst=1, byte_ready=0.
  - start -> HDR0 with error=0.
- start is ignored in HDR0, HDR1, DATA and CSUM.
- byte_valid while byte_ready=0 is ignored; the byte is held by the source.
- byte_valid deasserted mid-word stalls the loader with no timeout; byte index and accumulator are held.
- imem_waddr never exceeds N-1, so there is no wrap-around.
- Minimum latency from the CSUM transfer edge to done/core_rst change: 1 cycle.

Test Plan:
- Basic load:
  - Stimulus: start, then 02 00 | 13 00 10 00 | 93 00 20 00 | B0, byte_valid held high.
  - Response: writes addr0=0x00100013 and addr1=0x00200093, one imem_we pulse each. done=1 and core_rst=0 in the cycle after B0 is accepted; error=0.
- Bad checksum:
  - Stimulus: same frame with CSUM=B1.
  - Response: both writes still occur; error=1, done=0, core_rst stays 1, byte_ready=0 afterwards.
- Bad length:
  - Stimulus: header 00 00, then a separate run with 01 01 (257 > DEPTH).
  - Response: ERR after the second header byte, no imem_we, error=1.
- Stalls and idle bytes:
  - Stimulus: byte_valid high in IDLE; then the basic-load frame with random 0-3 cycle gaps between bytes.
  - Response: no consumption in IDLE; write sequence and final state identical to the basic load.
- Reset mid-load:
  - Stimulus: rst after 6 bytes of the basic frame.
  - Response: next cycle IDLE, busy=0, core_rst=1, imem_we=0, no second write. A subsequent full basic load succeeds.
- Reload:
  - Stimulus: start in DONE, then a 1-word frame 01 00 | 6F 00 00 00 | 6F.
  - Response: core_rst=1 and done=0 on the start edge; addr0=0x0000006F written; done=1 again.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills word-addressed instruction memory from a framed byte
// stream (LEN_LO, LEN_HI, 4*N payload bytes little-endian, CSUM = XOR of
// payload) and holds the core in reset until a load finishes with a good
// checksum.
module imem_loader #(
  parameter int ISIZE = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [ISIZE-1:0] imem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  // Widened so a 16-bit length can be compared without truncation.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]       state_reg, state_next;
  logic [15:0]      len_reg, len_next;
  logic [AW-1:0]    word_idx_reg, word_idx_next;
  logic [1:0]       byte_idx_reg, byte_idx_next;
  logic [7:0]       csum_reg, csum_next;

  logic             byte_ready_reg, byte_ready_next;
  logic             imem_we_reg, imem_we_next;
  logic [AW-1:0]    imem_waddr_reg, imem_waddr_next;
  logic [ISIZE-1:0] imem_wdata_reg, imem_wdata_next;
  logic             core_rst_reg, core_rst_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic             xfer;
  logic [15:0]      len_full;
  logic [23:0]      word_lo;

  // A byte moves only when the loader has advertised ready in this cycle.
  assign xfer     = byte_valid & byte_ready_reg;
  assign len_full = {byte_data, len_reg[7:0]};

  // Byte lanes 0..2 of the word under assembly; lane 3 goes straight out
  // with the write so no storage is needed for it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_reg;
    // Capture the payload byte whose position in the word matches this lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= 8'h00;
      end else if (state_reg == S_DATA && xfer && byte_idx_reg == 2'(gi)) begin
        lane_reg <= byte_data;
      end
    end
  end

  assign word_lo = {g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

  // Frame parser: next state, counters, checksum and memory write request.
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    word_idx_next   = word_idx_reg;
    byte_idx_next   = byte_idx_reg;
    csum_next       = csum_reg;
    imem_we_next    = 1'b0;
    imem_waddr_next = imem_waddr_reg;
    imem_wdata_next = imem_wdata_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_HDR0;
      end
      S_HDR0: begin
        if (xfer) begin
          len_next[7:0] = byte_data;
          state_next    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          len_next = len_full;
          if (len_full == 16'd0 || {1'b0, len_full} > DEPTH_W) begin
            state_next = S_ERR;
          end else begin
            word_idx_next = '0;
            byte_idx_next = 2'd0;
            csum_next     = 8'h00;
            state_next    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_next     = csum_reg ^ byte_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            imem_we_next    = 1'b1;
            imem_waddr_next = word_idx_reg;
            imem_wdata_next = {byte_data, word_lo};
            word_idx_next   = word_idx_reg + 1'b1;
            // Last word of the frame: only the checksum byte remains.
            if (16'(word_idx_reg) == len_reg - 16'd1) state_next = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_next = (byte_data == csum_reg) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // alongside it and change on the same edge as the state.
  always_comb begin
    byte_ready_next = (state_next == S_HDR0) || (state_next == S_HDR1) ||
                      (state_next == S_DATA) || (state_next == S_CSUM);
    busy_next       = byte_ready_next;
    done_next       = (state_next == S_DONE);
    error_next      = (state_next == S_ERR);
    core_rst_next   = (state_next != S_DONE);
  end

  // State and output registers; reset drops any write about to be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      len_reg        <= 16'd0;
      word_idx_reg   <= '0;
      byte_idx_reg   <= 2'd0;
      csum_reg       <= 8'h00;
      byte_ready_reg <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_waddr_reg <= '0;
      imem_wdata_reg <= '0;
      core_rst_reg   <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      word_idx_reg   <= word_idx_next;
      byte_idx_reg   <= byte_idx_next;
      csum_reg       <= csum_next;
      byte_ready_reg <= byte_ready_next;
      imem_we_reg    <= imem_we_next;
      imem_waddr_reg <= imem_waddr_next;
      imem_wdata_reg <= imem_wdata_next;
      core_rst_reg   <= core_rst_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  assign byte_ready = byte_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_waddr = imem_waddr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign core_rst   = core_rst_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives frames byte by byte and checks
// memory writes and status outputs against hand-computed values.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.ISIZE(32), .AW(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every cycle with the write strobe high, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_waddr);
      wr_data_q.push_back(imem_wdata);
      $display("write addr=%0d data=%08h", imem_waddr, imem_wdata);
    end
  end

  // Present one byte (called at a negedge) and return at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!byte_ready) begin
      errors++;
      $display("FAIL byte_accept: byte %02h ready=%b required=1 after 50 cycles", b, byte_ready);
    end else begin
      @(negedge clk);
      $display("byte %02h accepted", b);
    end
    byte_valid = 1'b0;
  endtask

  // Send frame_q; gap_mode inserts a fixed pattern of 0..3 idle cycles between bytes.
  task automatic send_frame(input int gap_mode);
    int gaps[4] = '{2, 0, 3, 1};
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (gap_mode != 0) begin
        for (int g = 0; g < gaps[i % 4]; g++) @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic basic_frame(input logic [7:0] csum);
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                8'h93, 8'h00, 8'h20, 8'h00, csum};
  endtask

  // Check the two writes of the basic frame and a successful finish.
  task automatic check_basic_result(input string tag);
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h00100013) begin
        errors++;
        $display("FAIL %s_word0: got addr=%0d data=%08h required addr=0 data=00100013",
                 tag, wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'h00200093) begin
        errors++;
        $display("FAIL %s_word1: got addr=%0d data=%08h required addr=1 data=00200093",
                 tag, wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if ({done, core_rst, error, byte_ready, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL %s_final: got done/core_rst/error/ready/busy=%b required 10000",
               tag, {done, core_rst, error, byte_ready, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({core_rst, byte_ready, busy, done, error, imem_we} !== 6'b100000 ||
        imem_waddr !== 8'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got core_rst/ready/busy/done/error/we=%b waddr=%0d wdata=%08h required 100000 0 0",
               {core_rst, byte_ready, busy, done, error, imem_we}, imem_waddr, imem_wdata);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    checks++;
    if ({busy, byte_ready, core_rst} !== 3'b111) begin
      errors++;
      $display("FAIL basic_hdr0: got busy/ready/core_rst=%b required 111", {busy, byte_ready, core_rst});
    end
    basic_frame(8'hB0);
    send_frame(0);
    check_basic_result("basic");
  endtask

  task automatic test_bad_csum();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    basic_frame(8'hB1);
    send_frame(0);
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++;
      $display("FAIL badcsum_write_count: got %0d required 2", wr_addr_q.size());
    end
    checks++;
    if ({error, done, core_rst, byte_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL badcsum_final: got error/done/core_rst/ready=%b required 1010",
               {error, done, core_rst, byte_ready});
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] hdrs[2][2] = '{'{8'h00, 8'h00}, '{8'h01, 8'h01}};
    for (int r = 0; r < 2; r++) begin
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      send_byte(hdrs[r][0]);
      send_byte(hdrs[r][1]);
      checks++;
      if ({error, done, core_rst, byte_ready, busy} !== 5'b10100) begin
        errors++;
        $display("FAIL badlen%0d_state: got error/done/core_rst/ready/busy=%b required 10100",
                 r, {error, done, core_rst, byte_ready, busy});
      end
      @(negedge clk);
      checks++;
      if (wr_addr_q.size() !== 0) begin
        errors++;
        $display("FAIL badlen%0d_writes: got %0d required 0", r, wr_addr_q.size());
      end
    end
  endtask

  task automatic test_stall_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_consume: cycle %0d got ready=%b busy=%b required 0 0", i, byte_ready, busy);
      end
    end
    byte_valid = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    basic_frame(8'hB0);
    send_frame(1);
    check_basic_result("stall");
  endtask

  task automatic test_reset_midload();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    basic_frame(8'hB0);
    for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, core_rst, imem_we, byte_ready, done, error} !== 6'b010000) begin
      errors++;
      $display("FAIL midrst_state: got busy/core_rst/we/ready/done/error=%b required 010000",
               {busy, core_rst, imem_we, byte_ready, done, error});
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 1) begin
      errors++;
      $display("FAIL midrst_writes: got %0d required 1", wr_addr_q.size());
    end
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_frame(0);
    check_basic_result("after_rst");
  endtask

  task automatic test_reload();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    checks++;
    if ({core_rst, done, busy} !== 3'b101) begin
      errors++;
      $display("FAIL reload_start: got core_rst/done/busy=%b required 101", {core_rst, done, busy});
    end
    frame_q = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h6F};
    send_frame(0);
    checks++;
    if (wr_addr_q.size() !== 1) begin
      errors++;
      $display("FAIL reload_write_count: got %0d required 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h0000006F) begin
        errors++;
        $display("FAIL reload_word0: got addr=%0d data=%08h required addr=0 data=0000006F",
                 wr_addr_q[0], wr_data_q[0]);
      end
    end
    checks++;
    if ({done, core_rst, error} !== 3'b100) begin
      errors++;
      $display("FAIL reload_final: got done/core_rst/error=%b required 100", {done, core_rst, error});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_stall_idle();
    test_reset_midload();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
